// File: rtl/led_share_arbiter_if.sv
// rtl/led_share_arbiter_if.sv - client/arbiter bundle for the shared LED bank
//
// Purpose: groups the request, pattern and grant-side signals exchanged
//          between the LED clients and led_share_arbiter.
// Signals:
//   req      NUM_REQ        per-client request, level-sensitive
//   pattern  NUM_REQ*LED_W  client i pattern at [i*LED_W +: LED_W]
//   grant    NUM_REQ        one-hot current owner, zero when idle
//   leds     LED_W          registered LED drive
//   busy     1              high while any client owns the bank
// Modports: master = client side, slave = arbiter side.
interface led_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LED_W   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LED_W-1:0] pattern;
  logic [NUM_REQ-1:0]       grant;
  logic [LED_W-1:0]         leds;
  logic                     busy;

  modport master (
    output req,
    output pattern,
    input  grant,
    input  leds,
    input  busy
  );

  modport slave (
    input  req,
    input  pattern,
    output grant,
    output leds,
    output busy
  );
endinterface

// File: rtl/led_share_arbiter.sv
// rtl/led_share_arbiter.sv - round-robin time-slice arbiter for the LED bank
//
// Purpose: grants the LED bank to one requesting client at a time, drives
//          that client's pattern, and rotates ownership every SLICE_CYCLES
//          cycles while others wait. Drives IDLE_PATTERN when nobody owns it.
// Ports:
//   clk_i     system clock
//   reset_ni  asynchronous active-low reset
//   bus       slave side of led_share_arbiter_if (req/pattern in,
//             grant/leds/busy out, all outputs registered)
module led_share_arbiter #(
  parameter int                NUM_REQ      = 4,
  parameter int                LED_W        = 4,
  parameter int                SLICE_CYCLES = 25000000,
  parameter logic [LED_W-1:0]  IDLE_PATTERN = '0
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  led_share_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SLICE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t             state_q,     state_d;
  logic [IDX_W-1:0]   owner_q,     owner_d;
  logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0]   slice_cnt_q, slice_cnt_d;
  logic [NUM_REQ-1:0] grant_q,     grant_d;
  logic [LED_W-1:0]   leds_q,      leds_d;
  logic               busy_q,      busy_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  // First requester at or after base, wrapping modulo NUM_REQ.
  // Result is {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   base);
    logic             found;
    logic [IDX_W-1:0] sel;
    int               idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(base) + k) % NUM_REQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      slice_cnt_q <= '0;
      grant_q     <= '0;
      leds_q      <= IDLE_PATTERN;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      slice_cnt_q <= slice_cnt_d;
      grant_q     <= grant_d;
      leds_q      <= leds_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    slice_cnt_d = slice_cnt_q;
    grant_d     = '0;
    leds_d      = IDLE_PATTERN;
    busy_d      = 1'b0;
    pick_found  = 1'b0;
    pick_idx    = '0;

    unique case (state_q)
      IDLE: begin
        {pick_found, pick_idx} = rr_pick(bus.req, rr_ptr_q);
        if (pick_found) begin
          state_d     = OWN;
          owner_d     = pick_idx;
          slice_cnt_d = RELOAD;
        end
      end
      OWN: begin
        // Decision edge: owner released, or its slice ran out. Scanning
        // from owner+1 lets a sole requester be re-granted after expiry,
        // while a releasing owner is skipped because its req is low.
        if (!bus.req[owner_q] || (slice_cnt_q == '0)) begin
          rr_ptr_d = ptr_inc(owner_q);
          {pick_found, pick_idx} = rr_pick(bus.req, rr_ptr_d);
          if (pick_found) begin
            owner_d     = pick_idx;
            slice_cnt_d = RELOAD;
          end else begin
            state_d     = IDLE;
            slice_cnt_d = '0;
          end
        end else begin
          slice_cnt_d = slice_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the post-edge owner so grant and leds move together.
    if (state_d == OWN) begin
      grant_d[owner_d] = 1'b1;
      leds_d           = bus.pattern[owner_d*LED_W +: LED_W];
      busy_d           = 1'b1;
    end
  end

  assign bus.grant = grant_q;
  assign bus.leds  = leds_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// tb/tb_led_share_arbiter.sv - directed self-checking bench for led_share_arbiter
module tb_led_share_arbiter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  led_share_arbiter_if #(.NUM_REQ(4), .LED_W(4)) bus_if ();

  led_share_arbiter #(
    .NUM_REQ      (4),
    .LED_W        (4),
    .SLICE_CYCLES (4),
    .IDLE_PATTERN (4'b0000)
  ) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] l);
    check({tag, ".grant"}, 32'(bus_if.grant), 32'(g));
    check({tag, ".leds"},  32'(bus_if.leds),  32'(l));
    check({tag, ".busy"},  32'(bus_if.busy),  32'(g != 4'b0000));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus_if.req = 4'b0000;
    step(2);
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    bus_if.req     = 4'b1111;
    bus_if.pattern = {4'h9, 4'h9, 4'hA, 4'h5};

    // 1: reset held with all clients requesting
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_out("rst_hold", 4'b0000, 4'h0);
    end
    bus_if.req = 4'b0000;
    reset_n = 1'b1;
    step(1);
    chk_out("idle", 4'b0000, 4'h0);

    // 2: single requester keeps the grant across slice reloads
    bus_if.req = 4'b0010;
    step(1);
    chk_out("single_first", 4'b0010, 4'hA);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("single_hold.grant", 32'(bus_if.grant), 32'h2);
    end

    // 3: two clients alternate every 4 cycles, client 0 first after reset
    do_reset();
    bus_if.pattern = {4'h0, 4'h9, 4'h0, 4'h5};
    bus_if.req = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (((i / 4) % 2) == 0) chk_out("rotate", 4'b0001, 4'h5);
      else                    chk_out("rotate", 4'b0100, 4'h9);
    end

    // 4a: owner 0 releases mid-slice, client 2 takes over with no gap
    do_reset();
    bus_if.req = 4'b0101;
    step(1);
    chk_out("rel_a0", 4'b0001, 4'h5);
    step(1);
    chk_out("rel_a1", 4'b0001, 4'h5);
    bus_if.req = 4'b0100;
    step(1);
    chk_out("rel_handoff", 4'b0100, 4'h9);

    // 4b: owner 0 releases with nobody waiting -> idle on that edge
    do_reset();
    bus_if.req = 4'b0001;
    step(2);
    chk_out("rel_b1", 4'b0001, 4'h5);
    bus_if.req = 4'b0000;
    step(1);
    chk_out("rel_idle", 4'b0000, 4'h0);

    // 5: pattern change mid-slice appears exactly one edge later
    do_reset();
    bus_if.pattern = {4'h0, 4'h0, 4'h3, 4'h0};
    bus_if.req = 4'b0010;
    step(2);
    chk_out("pat_before", 4'b0010, 4'h3);
    bus_if.pattern = {4'h0, 4'h0, 4'hC, 4'h0};
    #1;
    check("pat_no_comb.leds", 32'(bus_if.leds), 32'h3);
    step(1);
    chk_out("pat_after", 4'b0010, 4'hC);

    // 6: asynchronous reset mid-slice, then release with 4'b1001
    do_reset();
    bus_if.pattern = {4'h7, 4'h9, 4'h0, 4'h5};
    bus_if.req = 4'b0100;
    step(2);
    chk_out("areset_pre", 4'b0100, 4'h9);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("areset_now", 4'b0000, 4'h0);
    bus_if.req = 4'b1001;
    reset_n = 1'b1;
    step(1);
    chk_out("areset_release", 4'b0001, 4'h5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
